// File: rtl/kmu_pkg.sv
// Shared types and constants for the kmu zip/unzip sequencing path.
// Benches use ZS_LOG2W to derive the pass count that returns an operand unchanged.
package kmu_pkg;

  typedef enum logic [1:0] {ZS_IDLE, ZS_RUN, ZS_DONE} zipseq_state_t;

  localparam int ZS_WIDTH = 64;
  localparam int ZS_LOG2W = $clog2(ZS_WIDTH);

endpackage

// File: rtl/zip_sequencer_if.sv
// Operand/result handshake bundle for zip_sequencer.
// The master drives operands and consumes results; the slave is the engine.
interface zip_sequencer_if #(
  parameter int WIDTH = 64,
  parameter int CNTW  = 3
);

  logic             Flush;
  logic             InValid;
  logic             InReady;
  logic [WIDTH-1:0] A;
  logic             ZipSelect;
  logic [CNTW-1:0]  Count;
  logic             OutValid;
  logic             OutReady;
  logic [WIDTH-1:0] Result;
  logic             Busy;

  modport master (
    output Flush, InValid, A, ZipSelect, Count, OutReady,
    input  InReady, OutValid, Result, Busy
  );

  modport slave (
    input  Flush, InValid, A, ZipSelect, Count, OutReady,
    output InReady, OutValid, Result, Busy
  );

endinterface

// File: rtl/zipper.sv
// Single-cycle perfect shuffle: zip interleaves the low and high halves,
// unzip gathers even bits into the low half and odd bits into the high half.
module zipper #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic             sel_i,
  output logic [WIDTH-1:0] result_o
);

  localparam int HALF = WIDTH / 2;

  logic [WIDTH-1:0] zipped;
  logic [WIDTH-1:0] unzipped;

  for (genvar i = 0; i < HALF; i++) begin : gShuffle
    assign zipped[2*i]        = data_i[i];
    assign zipped[2*i+1]      = data_i[i+HALF];
    assign unzipped[i]        = data_i[2*i];
    assign unzipped[i+HALF]   = data_i[2*i+1];
  end

  assign result_o = sel_i ? unzipped : zipped;

endmodule

// File: rtl/zip_sequencer.sv
// Multi-cycle zip/unzip engine: loads an operand, applies Count shuffle passes
// one per cycle through the zipper stage, then holds the result until consumed.
module zip_sequencer
  import kmu_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int CNTW  = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  zip_sequencer_if.slave   bus
);

  zipseq_state_t    state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             sel_q, sel_d;
  logic [CNTW-1:0]  rem_q, rem_d;
  logic [WIDTH-1:0] zipResult;

  zipper #(.WIDTH(WIDTH)) uZipper (
    .data_i   (data_q),
    .sel_i    (sel_q),
    .result_o (zipResult)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ZS_IDLE;
      data_q  <= '0;
      sel_q   <= 1'b0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      rem_q   <= rem_d;
    end
  end

  // Flush wins over both accept and consume; the datapath simply holds.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sel_d   = sel_q;
    rem_d   = rem_q;
    if (bus.Flush) begin
      state_d = ZS_IDLE;
    end else begin
      case (state_q)
        ZS_IDLE: begin
          if (bus.InValid) begin
            data_d  = bus.A;
            sel_d   = bus.ZipSelect;
            rem_d   = bus.Count;
            state_d = (bus.Count == '0) ? ZS_DONE : ZS_RUN;
          end
        end
        ZS_RUN: begin
          data_d = zipResult;
          rem_d  = rem_q - CNTW'(1);
          if (rem_q == CNTW'(1)) begin
            state_d = ZS_DONE;
          end
        end
        ZS_DONE: begin
          if (bus.OutReady) begin
            state_d = ZS_IDLE;
          end
        end
        default: begin
          state_d = ZS_IDLE;
        end
      endcase
    end
  end

  assign bus.InReady  = (state_q == ZS_IDLE);
  assign bus.OutValid = (state_q == ZS_DONE);
  assign bus.Busy     = (state_q != ZS_IDLE);
  assign bus.Result   = data_q;

  // A stalled result must not move, and RUN is never entered with nothing left to do.
  holdResult: assert property (@(posedge clk) disable iff (!reset_n)
    (state_q == ZS_DONE && !bus.OutReady && !bus.Flush) |=> (state_q == ZS_DONE && $stable(data_q)));

  runHasWork: assert property (@(posedge clk) disable iff (!reset_n)
    (state_q == ZS_RUN) |-> (rem_q != '0));

endmodule

// File: tb/tb_zip_sequencer.sv
// Scoreboard bench for zip_sequencer: stimulus queues hand-computed results,
// a negedge monitor pops and compares each result as it is consumed.
module tb_zip_sequencer;
  import kmu_pkg::*;

  localparam int W  = 64;
  localparam int CW = 3;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [W-1:0] expQ[$];

  always #5 clk = ~clk;

  zip_sequencer_if #(.WIDTH(W), .CNTW(CW)) bus ();

  zip_sequencer #(.WIDTH(W), .CNTW(CW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  task automatic checkOutput(input string name, input logic [W-1:0] actual, input logic [W-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Monitor: a result is consumed at the next posedge whenever valid and ready are both high.
  always @(negedge clk) begin
    if (reset_n && bus.OutValid && bus.OutReady) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected result: got %h expected none", bus.Result);
      end else begin
        checkOutput("result", bus.Result, expQ.pop_front());
      end
    end
  end

  task automatic applyStimulus(input logic [W-1:0] a, input logic sel, input logic [CW-1:0] cnt,
                               input logic [W-1:0] expected, input string name);
    bit seen = 1'b0;
    int n = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      seen = bus.InReady;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s ready: got 0 expected 1", name);
      return;
    end
    expQ.push_back(expected);
    bus.InValid   = 1'b1;
    bus.A         = a;
    bus.ZipSelect = sel;
    bus.Count     = cnt;
    @(posedge clk);
    #1 bus.InValid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      n++;
      seen = bus.OutValid;
    end
    checkOutput({name, " latency"}, W'(n), W'(int'(cnt) + 1));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit seen;
    bus.Flush     = 1'b0;
    bus.InValid   = 1'b0;
    bus.A         = '0;
    bus.ZipSelect = 1'b0;
    bus.Count     = '0;
    bus.OutReady  = 1'b1;

    #12;
    checkOutput("reset InReady", W'(bus.InReady), W'(1));
    checkOutput("reset OutValid", W'(bus.OutValid), W'(0));
    checkOutput("reset Busy", W'(bus.Busy), W'(0));
    checkOutput("reset Result", bus.Result, '0);
    @(negedge clk);
    reset_n = 1'b1;

    // Directed vectors: operand, direction, passes, expected result.
    applyStimulus(64'hFFFF_FFFF_0000_0000, 1'b0, 3'd1, 64'hAAAA_AAAA_AAAA_AAAA, "zip1");
    applyStimulus(64'hAAAA_AAAA_AAAA_AAAA, 1'b1, 3'd1, 64'hFFFF_FFFF_0000_0000, "unzip1");
    applyStimulus(64'h0000_0000_FFFF_FFFF, 1'b0, 3'd1, 64'h5555_5555_5555_5555, "zip1 low");
    applyStimulus(64'h5555_5555_5555_5555, 1'b1, 3'd1, 64'h0000_0000_FFFF_FFFF, "unzip1 low");
    applyStimulus(64'h0123_4567_89AB_CDEF, 1'b0, 3'd0, 64'h0123_4567_89AB_CDEF, "count0");
    applyStimulus(64'h0123_4567_89AB_CDEF, 1'b0, CW'(ZS_LOG2W), 64'h0123_4567_89AB_CDEF, "zip6");
    applyStimulus(64'h0123_4567_89AB_CDEF, 1'b1, CW'(ZS_LOG2W), 64'h0123_4567_89AB_CDEF, "unzip6");
    applyStimulus(64'hFFFF_FFFF_0000_0000, 1'b0, 3'd7, 64'hAAAA_AAAA_AAAA_AAAA, "zip7");
    applyStimulus(64'hFFFF_FFFF_0000_0000, 1'b0, 3'd2, 64'hCCCC_CCCC_CCCC_CCCC, "zip2");

    // Backpressure with InValid held high; the second operand swaps in after the first accept.
    bus.OutReady = 1'b0;
    @(negedge clk);
    expQ.push_back(64'h5555_5555_5555_5555);
    bus.InValid   = 1'b1;
    bus.A         = 64'h0000_0000_FFFF_FFFF;
    bus.ZipSelect = 1'b0;
    bus.Count     = 3'd1;
    @(posedge clk);
    #1;
    bus.A     = 64'h0123_4567_89AB_CDEF;
    bus.Count = 3'd0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = bus.OutValid;
    end
    checkOutput("bp reach done", W'(seen), W'(1));
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput("bp OutValid", W'(bus.OutValid), W'(1));
      checkOutput("bp InReady", W'(bus.InReady), W'(0));
      checkOutput("bp Result", bus.Result, 64'h5555_5555_5555_5555);
    end
    expQ.push_back(64'h0123_4567_89AB_CDEF);
    @(posedge clk);
    #1 bus.OutReady = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("bp idle after release", W'(bus.InReady), W'(1));
    @(posedge clk);
    #1 bus.InValid = 1'b0;
    @(negedge clk);
    checkOutput("bp second valid", W'(bus.OutValid), W'(1));
    @(posedge clk);
    #1;

    // Flush in RUN when three passes remain.
    @(negedge clk);
    bus.InValid   = 1'b1;
    bus.A         = 64'hFFFF_FFFF_0000_0000;
    bus.ZipSelect = 1'b0;
    bus.Count     = 3'd5;
    @(posedge clk);
    #1 bus.InValid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 bus.Flush = 1'b1;
    @(negedge clk);
    checkOutput("flush busy before", W'(bus.Busy), W'(1));
    @(posedge clk);
    #1 bus.Flush = 1'b0;
    @(negedge clk);
    checkOutput("flush busy after", W'(bus.Busy), W'(0));
    checkOutput("flush InReady after", W'(bus.InReady), W'(1));
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.OutValid) seen = 1'b1;
    end
    checkOutput("flush no OutValid", W'(seen), W'(0));
    applyStimulus(64'hFFFF_FFFF_0000_0000, 1'b0, 3'd1, 64'hAAAA_AAAA_AAAA_AAAA, "post flush");

    // Flush together with InValid in IDLE must not accept.
    @(negedge clk);
    bus.Flush   = 1'b1;
    bus.InValid = 1'b1;
    bus.A       = 64'h0123_4567_89AB_CDEF;
    bus.Count   = 3'd0;
    @(posedge clk);
    #1;
    bus.Flush   = 1'b0;
    bus.InValid = 1'b0;
    @(negedge clk);
    checkOutput("flush accept busy", W'(bus.Busy), W'(0));
    checkOutput("flush accept OutValid", W'(bus.OutValid), W'(0));
    checkOutput("flush accept InReady", W'(bus.InReady), W'(1));

    // Asynchronous reset between edges, mid-RUN.
    @(negedge clk);
    bus.InValid   = 1'b1;
    bus.A         = 64'hFFFF_FFFF_0000_0000;
    bus.ZipSelect = 1'b0;
    bus.Count     = 3'd6;
    @(posedge clk);
    #1 bus.InValid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    checkOutput("areset OutValid", W'(bus.OutValid), W'(0));
    checkOutput("areset Busy", W'(bus.Busy), W'(0));
    checkOutput("areset InReady", W'(bus.InReady), W'(1));
    checkOutput("areset Result", bus.Result, '0);
    @(negedge clk);
    reset_n = 1'b1;
    applyStimulus(64'hFFFF_FFFF_0000_0000, 1'b0, 3'd1, 64'hAAAA_AAAA_AAAA_AAAA, "post reset");

    repeat (3) @(negedge clk);
    checkOutput("queue drained", W'(expQ.size()), W'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
